// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Execute-issue stage in front of the ALU. It decodes opcode/funct3/f7b5
//   into a 4-bit ALU op, selects operands a/b, and registers the result
//   behind a valid/ready handshake. A one-entry skid register sits behind the
//   main output register, so two entries can be buffered in total.
//
//   Optional build macro: ALU_ISSUE_FWD_EN adds a single forwarding port set
//   (in_rs1_idx, in_rs2_idx, fwd_valid, fwd_rd, fwd_data). At acceptance,
//   fwd_data replaces rs1/rs2 when the index matches a non-zero fwd_rd.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   flush               synchronous kill of both buffered entries
//   in_valid/in_ready   upstream handshake; in_ready = skid entry empty
//   in_opcode/funct3/f7b5, in_rs1_val, in_rs2_val, in_imm, in_pc, in_rd
//                       decoded instruction fields and operands
//   out_valid/out_ready downstream handshake
//   out_a, out_b, out_alu_op, out_rd, out_illegal
//                       registered ALU operands, op code, destination and
//                       illegal flag
module alu_issue_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic            in_f7b5,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic [RD_W-1:0] in_rd,
`ifdef ALU_ISSUE_FWD_EN
  input  logic [RD_W-1:0] in_rs1_idx,
  input  logic [RD_W-1:0] in_rs2_idx,
  input  logic            fwd_valid,
  input  logic [RD_W-1:0] fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_alu_op,
  output logic [RD_W-1:0] out_rd,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;

  logic [XLEN-1:0] rs1_p0, rs2_p0;
  logic [XLEN-1:0] a_p0, b_p0;
  logic [3:0]      op_p0;
  logic            ill_p0;

  logic            vld_p1;
  logic            sk_vld_p1;
  logic [XLEN-1:0] sk_a_p1, sk_b_p1;
  logic [3:0]      sk_op_p1;
  logic [RD_W-1:0] sk_rd_p1;
  logic            sk_ill_p1;

  logic accept, main_load;

  // ---- p0: operand forwarding and combinational decode ----
`ifdef ALU_ISSUE_FWD_EN
  always_comb begin
    rs1_p0 = in_rs1_val;
    rs2_p0 = in_rs2_val;
    if (fwd_valid && (fwd_rd != '0) && (fwd_rd == in_rs1_idx)) rs1_p0 = fwd_data;
    if (fwd_valid && (fwd_rd != '0) && (fwd_rd == in_rs2_idx)) rs2_p0 = fwd_data;
  end
`else
  assign rs1_p0 = in_rs1_val;
  assign rs2_p0 = in_rs2_val;
`endif

  always_comb begin
    a_p0   = '0;
    b_p0   = '0;
    op_p0  = OP_ADD;
    ill_p0 = 1'b0;
    case (in_opcode)
      OPC_R, OPC_I: begin
        a_p0 = rs1_p0;
        b_p0 = (in_opcode == OPC_R) ? rs2_p0 : in_imm;
        case (in_funct3)
          3'b000:  op_p0 = ((in_opcode == OPC_R) && in_f7b5) ? OP_SUB : OP_ADD;
          3'b001:  op_p0 = OP_SLL;
          3'b010:  ill_p0 = 1'b1;  // signed compare has no ALU op
          3'b011:  op_p0 = OP_SLTU;
          3'b100:  op_p0 = OP_XOR;
          3'b101:  op_p0 = in_f7b5 ? OP_SRA : OP_SRL;
          3'b110:  op_p0 = OP_OR;
          default: op_p0 = OP_AND;
        endcase
      end
      OPC_LUI:   b_p0 = in_imm;
      OPC_AUIPC: begin
        a_p0 = in_pc;
        b_p0 = in_imm;
      end
      OPC_LOAD, OPC_STORE: begin
        a_p0 = rs1_p0;
        b_p0 = in_imm;
      end
      // Unknown opcodes still flow downstream so the trap is raised in order.
      default:   ill_p0 = 1'b1;
    endcase
  end

  assign in_ready  = ~sk_vld_p1;
  assign accept    = in_valid && in_ready;
  assign main_load = ~vld_p1 || out_ready;
  assign out_valid = vld_p1;

  // ---- p1: main output register and skid register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      sk_vld_p1   <= 1'b0;
      out_a       <= '0;
      out_b       <= '0;
      out_alu_op  <= OP_ADD;
      out_rd      <= '0;
      out_illegal <= 1'b0;
      sk_a_p1     <= '0;
      sk_b_p1     <= '0;
      sk_op_p1    <= OP_ADD;
      sk_rd_p1    <= '0;
      sk_ill_p1   <= 1'b0;
    end else if (flush) begin
      vld_p1    <= 1'b0;
      sk_vld_p1 <= 1'b0;
    end else if (main_load) begin
      if (sk_vld_p1) begin
        // in_ready is low while the skid is full, so no accept competes here.
        vld_p1      <= 1'b1;
        sk_vld_p1   <= 1'b0;
        out_a       <= sk_a_p1;
        out_b       <= sk_b_p1;
        out_alu_op  <= sk_op_p1;
        out_rd      <= sk_rd_p1;
        out_illegal <= sk_ill_p1;
      end else if (accept) begin
        vld_p1      <= 1'b1;
        out_a       <= a_p0;
        out_b       <= b_p0;
        out_alu_op  <= op_p0;
        out_rd      <= in_rd;
        out_illegal <= ill_p0;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (accept) begin
      sk_vld_p1 <= 1'b1;
      sk_a_p1   <= a_p0;
      sk_b_p1   <= b_p0;
      sk_op_p1  <= op_p0;
      sk_rd_p1  <= in_rd;
      sk_ill_p1 <= ill_p0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  localparam int XLEN = 32;
  localparam int RD_W = 5;

  logic            clk = 1'b0;
  logic            rst_n, flush, in_valid, in_ready;
  logic [6:0]      in_opcode;
  logic [2:0]      in_funct3;
  logic            in_f7b5;
  logic [XLEN-1:0] in_rs1_val, in_rs2_val, in_imm, in_pc;
  logic [RD_W-1:0] in_rd;
`ifdef ALU_ISSUE_FWD_EN
  logic [RD_W-1:0] in_rs1_idx, in_rs2_idx, fwd_rd;
  logic            fwd_valid;
  logic [XLEN-1:0] fwd_data;
`endif
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_a, out_b;
  logic [3:0]      out_alu_op;
  logic [RD_W-1:0] out_rd;
  logic            out_illegal;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_f7b5(in_f7b5),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_imm(in_imm), .in_pc(in_pc), .in_rd(in_rd),
`ifdef ALU_ISSUE_FWD_EN
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_alu_op(out_alu_op),
    .out_rd(out_rd), .out_illegal(out_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic [31:0] pc,
                        input logic [4:0] rd);
    in_valid   = 1'b1;
    in_opcode  = opc;
    in_funct3  = f3;
    in_f7b5    = f7;
    in_rs1_val = rs1;
    in_rs2_val = rs2;
    in_imm     = imm;
    in_pc      = pc;
    in_rd      = rd;
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = '0; in_funct3 = '0; in_f7b5 = 1'b0;
    in_rs1_val = '0; in_rs2_val = '0; in_imm = '0; in_pc = '0; in_rd = '0;
`ifdef ALU_ISSUE_FWD_EN
    in_rs1_idx = '0; in_rs2_idx = '0; fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;
`endif
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_b", out_b, 32'd0);
    chk("rst_alu_op", 32'(out_alu_op), 32'd0);
    chk("rst_illegal", 32'(out_illegal), 32'd0);
    #10 rst_n = 1'b1;

    // R-type sub
    set_in(7'b0110011, 3'b000, 1'b1, 32'd10, 32'd3, 32'd0, 32'd0, 5'd7);
    tick();
    chk("sub_valid", 32'(out_valid), 32'd1);
    chk("sub_a", out_a, 32'd10);
    chk("sub_b", out_b, 32'd3);
    chk("sub_op", 32'(out_alu_op), 32'h1);
    chk("sub_rd", 32'(out_rd), 32'd7);

    // srai
    set_in(7'b0010011, 3'b101, 1'b1, 32'h8000_0000, 32'd9, 32'h404, 32'd0, 5'd1);
    tick();
    chk("srai_op", 32'(out_alu_op), 32'h7);
    chk("srai_a", out_a, 32'h8000_0000);
    chk("srai_b", out_b, 32'h404);
    chk("srai_ill", 32'(out_illegal), 32'd0);

    // slti is illegal
    set_in(7'b0010011, 3'b010, 1'b0, 32'd5, 32'd0, 32'd1, 32'd0, 5'd2);
    tick();
    chk("slti_ill", 32'(out_illegal), 32'd1);
    chk("slti_op", 32'(out_alu_op), 32'h0);

    // addi with f7b5 set stays add (sub only for R type)
    set_in(7'b0010011, 3'b000, 1'b1, 32'd4, 32'd0, 32'h400, 32'd0, 5'd3);
    tick();
    chk("addi_f7_op", 32'(out_alu_op), 32'h0);
    chk("addi_f7_ill", 32'(out_illegal), 32'd0);

    // R-type and, sltu, srl
    set_in(7'b0110011, 3'b111, 1'b0, 32'hF0, 32'h3C, 32'd0, 32'd0, 5'd4);
    tick();
    chk("and_op", 32'(out_alu_op), 32'h4);
    chk("and_b", out_b, 32'h3C);
    set_in(7'b0110011, 3'b011, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0, 5'd4);
    tick();
    chk("sltu_op", 32'(out_alu_op), 32'h8);
    set_in(7'b0010011, 3'b101, 1'b0, 32'd1, 32'd2, 32'd3, 32'd0, 5'd4);
    tick();
    chk("srli_op", 32'(out_alu_op), 32'h6);

    // AUIPC
    set_in(7'b0010111, 3'b000, 1'b0, 32'd99, 32'd98, 32'h5000, 32'h1000, 5'd5);
    tick();
    chk("auipc_a", out_a, 32'h1000);
    chk("auipc_b", out_b, 32'h5000);
    chk("auipc_op", 32'(out_alu_op), 32'h0);

    // LUI
    set_in(7'b0110111, 3'b000, 1'b0, 32'd99, 32'd98, 32'hABCDE000, 32'h1000, 5'd6);
    tick();
    chk("lui_a", out_a, 32'd0);
    chk("lui_b", out_b, 32'hABCDE000);

    // STORE
    set_in(7'b0100011, 3'b010, 1'b0, 32'h2000, 32'd98, 32'h10, 32'h1000, 5'd0);
    tick();
    chk("store_a", out_a, 32'h2000);
    chk("store_b", out_b, 32'h10);
    chk("store_ill", 32'(out_illegal), 32'd0);

    // Unknown opcode still passes downstream, flagged illegal
    set_in(7'b1110011, 3'b000, 1'b0, 32'd11, 32'd12, 32'd13, 32'd14, 5'd9);
    tick();
    chk("bad_valid", 32'(out_valid), 32'd1);
    chk("bad_ill", 32'(out_illegal), 32'd1);
    chk("bad_a", out_a, 32'd0);
    chk("bad_b", out_b, 32'd0);

    in_valid = 1'b0;
    tick();
    chk("idle_valid", 32'(out_valid), 32'd0);

    // Backpressure: A, B accepted, C waits
    out_ready = 1'b0;
    set_in(7'b0010011, 3'b000, 1'b0, 32'hA, 32'd0, 32'd0, 32'd0, 5'd1);
    tick();
    chk("bp_a_ready", 32'(in_ready), 32'd1);
    set_in(7'b0010011, 3'b000, 1'b0, 32'hB, 32'd0, 32'd0, 32'd0, 5'd2);
    tick();
    chk("bp_b_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_rd", 32'(out_rd), 32'd1);
    set_in(7'b0010011, 3'b000, 1'b0, 32'hC, 32'd0, 32'd0, 32'd0, 5'd3);
    tick();
    chk("bp_stable_a", out_a, 32'hA);
    chk("bp_stable_rd", 32'(out_rd), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_2nd_rd", 32'(out_rd), 32'd2);
    chk("bp_2nd_a", out_a, 32'hB);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    tick();
    chk("bp_3rd_rd", 32'(out_rd), 32'd3);
    chk("bp_3rd_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Flush with both entries full, then flush against an acceptable input
    out_ready = 1'b0;
    set_in(7'b0010011, 3'b000, 1'b0, 32'hD, 32'd0, 32'd0, 32'd0, 5'd10);
    tick();
    set_in(7'b0010011, 3'b000, 1'b0, 32'hE, 32'd0, 32'd0, 32'd0, 5'd11);
    tick();
    chk("fl_full_ready", 32'(in_ready), 32'd0);
    flush = 1'b1;
    set_in(7'b0010011, 3'b000, 1'b0, 32'hF, 32'd0, 32'd0, 32'd0, 5'd12);
    tick();
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    tick();
    chk("fl_prio_valid", 32'(out_valid), 32'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("fl_no_ghost", 32'(out_valid), 32'd0);
    set_in(7'b0010011, 3'b000, 1'b0, 32'h1234, 32'd0, 32'd0, 32'd0, 5'd13);
    tick();
    chk("fl_recover_rd", 32'(out_rd), 32'd13);
    chk("fl_recover_a", out_a, 32'h1234);
    in_valid = 1'b0;

`ifdef ALU_ISSUE_FWD_EN
    set_in(7'b0110011, 3'b000, 1'b0, 32'h11, 32'h22, 32'd0, 32'd0, 5'd1);
    in_rs1_idx = 5'd5; in_rs2_idx = 5'd6;
    fwd_valid = 1'b1; fwd_rd = 5'd5; fwd_data = 32'h77;
    tick();
    chk("fwd_a", out_a, 32'h77);
    chk("fwd_b", out_b, 32'h22);
    in_rs1_idx = 5'd0; fwd_rd = 5'd0;
    tick();
    chk("fwd_x0_a", out_a, 32'h11);
    in_valid = 1'b0; fwd_valid = 1'b0;
    tick();
`endif

    // Reset mid-transfer: entries vanish at once
    out_ready = 1'b0;
    set_in(7'b0010011, 3'b000, 1'b0, 32'h55, 32'd0, 32'd0, 32'd0, 5'd14);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_a", out_a, 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    #10 rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Execute-issue stage sitting directly upstream of the ALU control block.
- Accepts decoded instruction fields, register operands and PC, and maps opcode/funct3/funct7[5] onto the 4-bit ALU operation code.
- Selects the a/b operands and registers everything behind a valid/ready handshake with a 2-entry skid buffer.
- Registered outputs drive the ALU a, b and alu_op inputs directly.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
RD_W, 5, destination register index width.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of all buffered entries
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept; registered, equals "skid entry empty"
in_opcode  in  7  instr[6:0]
in_funct3  in  3  instr[14:12]
in_f7b5  in  1  instr[30]
in_rs1_val  in  XLEN  rs1 register value
in_rs2_val  in  XLEN  rs2 register value
in_imm  in  XLEN  sign-extended immediate from decode
in_pc  in  XLEN  instruction PC
in_rd  in  RD_W  destination index
out_valid  out  1  main entry valid
out_ready  in  1  ALU/EX consumer accepts
out_a  out  XLEN  ALU operand a
out_b  out  XLEN  ALU operand b
out_alu_op  out  4  ALU operation code
out_rd  out  RD_W  destination index
out_illegal  out  1  instruction not executable by this ALU

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, skid valid=0, in_ready=1; out_a, out_b, out_rd and skid data all 0; out_alu_op=4'b0000; out_illegal=0.
- ALU op codes: 0000 add, 0001 sub, 0010 xor, 0011 or, 0100 and, 0101 sll, 0110 srl, 0111 sra, 1000 sltu.
- Decode for R type (0110011) and I-ALU type (0010011):
  - a = rs1_val.
  - b = rs2_val for R type, imm for I-ALU type.
  - funct3 000 gives add; it gives sub only when R type and f7b5=1.
  - 001 sll; 011 sltu; 100 xor; 101 srl, or sra when f7b5=1; 110 or; 111 and.
  - 010 (slt/slti) is not supported by the ALU: illegal=1, op=0000.
- LUI (0110111): a=0, b=imm, add.
- AUIPC (0010111): a=pc, b=imm, add.
- LOAD (0000011) and STORE (0100011): a=rs1_val, b=imm, add.
- Any other opcode: illegal=1, a=0, b=0, op=0000; the entry is still passed downstream so the exception is raised in order.
- Decode is combinational on the input side; the result is captured in the register at acceptance. Latency is 1 cycle from accept to out_valid.
- Accept condition: in_valid && in_ready.
- Main register loads when it is empty or is draining (out_valid && out_ready):
  - from skid if skid is valid, otherwise from the accepted input.
- Skid captures the accepted input when the main register is full and not draining. in_ready drops the following cycle.
- The skid drains into main on the first main-drain cycle. in_ready returns to 1 the cycle after.
- Ordering is preserved in all cases; no entry is dropped or duplicated under any in_valid/out_ready pattern.
- Simultaneous drain and accept with skid empty: main reloads from input; out_valid stays 1.
- flush=1: on the next edge both valid bits clear and in_ready=1. flush has priority over an accept in the same cycle, so that accepted entry is discarded. Data registers may keep stale values.
- Data outputs hold stable while out_valid && !out_ready (AXI-style stability).
- Reset asserted mid-transfer: all entries are lost immediately and the block returns to the reset state.

Optional Feature:
ALU_ISSUE_FWD_EN
- Defined: adds ports in_rs1_idx[RD_W], in_rs2_idx[RD_W], fwd_valid[1], fwd_rd[RD_W], fwd_data[XLEN].
  - At acceptance, if fwd_valid && fwd_rd != 0 && fwd_rd == in_rsN_idx, fwd_data replaces in_rsN_val before operand selection.
  - Substitution happens only where rsN is actually used (not for pc, imm or the LUI zero).
  - Entries already sitting in the skid buffer are not re-forwarded.
- Undefined: these ports are absent and register values pass through unchanged.

Test Plan:
1. Reset, then R-type sub (f3=000, f7b5=1), rs1=10, rs2=3, out_ready=1 -> next cycle out_valid=1, a=10, b=3, op=0001.
2. I-type srai (f3=101, f7b5=1), rs1=0x80000000, imm=0x404 -> op=0111, b=0x404; slti (f3=010) -> illegal=1, op=0000.
3. AUIPC pc=0x1000, imm=0x5000 -> a=0x1000, b=0x5000, op=0000; LUI imm=0xABCDE000 -> a=0.
4. Backpressure: 3 back-to-back entries, out_ready=0 -> in_ready=0 after 2 accepts. Release out_ready -> all 3 emerge in order, none lost.
5. flush asserted with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed entries never appear.
6. (ALU_ISSUE_FWD_EN) rs1_idx=5, fwd_valid=1, fwd_rd=5, fwd_data=0x77 -> a=0x77. Repeat with fwd_rd=0 -> a=rs1_val.
